// File: rtl/alu_control_pkg.sv
// Shared definitions for the ALU control path: operation-class codes from
// the main control FSM and the 3-bit ALU operation select.
// Used by alu_control, the ALU/flag unit and the control FSM.
package alu_control_pkg;

  // Operation class driven by the main control FSM.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NEG   = 2'b11;

  // ALU operation select.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_NAND = 3'b010;
  localparam logic [2:0] ALU_ASL  = 3'b011;
  localparam logic [2:0] ALU_NEG  = 3'b100;
  localparam logic [2:0] ALU_ASR  = 3'b101;
  localparam logic [2:0] ALU_LSR  = 3'b110;
  localparam logic [2:0] ALU_LSL  = 3'b111;

  // True for every shift operation select.
  function automatic logic alu_is_shift(input logic [2:0] op);
    case (op)
      ALU_ASL, ALU_ASR, ALU_LSR, ALU_LSL: alu_is_shift = 1'b1;
      default:                            alu_is_shift = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_control_decode.sv
// Combinational decode of operation class and function code into the
// ALU operation select plus its shift/subtract qualifiers and an
// undefined-code flag. Undefined codes fall back to add.
module alu_control_decode
  import alu_control_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [3:0] functcode,
  output logic [2:0] alucont,
  output logic       illegal,
  output logic       is_shift,
  output logic       is_sub
);

  // Map the operation class (and function code when asked) to an ALU op.
  // NOTE: defaults assigned first so every path drives every output; no latches.
  always_comb begin
    alucont = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_NEG: alucont = ALU_NEG;
      ALUOP_FUNCT: begin
        if (functcode[3]) begin
          alucont = ALU_ADD;
          illegal = 1'b1;
        end else begin
          alucont = functcode[2:0];
        end
      end
      default: begin
        alucont = ALU_ADD;
        illegal = 1'b0;
      end
    endcase
  end

  // Qualifiers follow directly from the selected operation.
  always_comb begin
    is_shift = alu_is_shift(alucont);
    is_sub   = (alucont == ALU_SUB);
  end

endmodule

// File: rtl/alu_control.sv
// ALU control: registers the decoded ALU select so it is stable for the
// whole execute cycle, and tracks undefined function codes.
// Optional feature: ALU_CTRL_ILLEGAL_TRAP_EN enables the illegal pulse and
// the sticky illegal indicator; without it both read 0 and illegal_clr is
// ignored.
module alu_control
  import alu_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] aluop,
  input  logic [3:0] functcode,
  input  logic       illegal_clr,
  output logic [2:0] alucont,
  output logic       is_shift,
  output logic       is_sub,
  output logic       illegal,
  output logic       illegal_sticky
);

  logic [2:0] dec_alucont;
  logic       dec_illegal;
  logic       dec_is_shift;
  logic       dec_is_sub;

  alu_control_decode u_decode (
    .aluop     (aluop),
    .functcode (functcode),
    .alucont   (dec_alucont),
    .illegal   (dec_illegal),
    .is_shift  (dec_is_shift),
    .is_sub    (dec_is_sub)
  );

  logic [2:0] alucont_d, alucont_q;
  logic       is_shift_d, is_shift_q;
  logic       is_sub_d, is_sub_q;

  // Load the decoded select on en, otherwise hold it.
  always_comb begin
    alucont_d  = alucont_q;
    is_shift_d = is_shift_q;
    is_sub_d   = is_sub_q;
    if (en) begin
      alucont_d  = dec_alucont;
      is_shift_d = dec_is_shift;
      is_sub_d   = dec_is_sub;
    end
  end

  // Select registers, cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignment only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alucont_q  <= ALU_ADD;
      is_shift_q <= 1'b0;
      is_sub_q   <= 1'b0;
    end else begin
      alucont_q  <= alucont_d;
      is_shift_q <= is_shift_d;
      is_sub_q   <= is_sub_d;
    end
  end

  assign alucont  = alucont_q;
  assign is_shift = is_shift_q;
  assign is_sub   = is_sub_q;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_d, illegal_q;
  logic sticky_d, sticky_q;

  // Pulse on each accepted undefined decode; sticky set wins over clear.
  always_comb begin
    illegal_d = en & dec_illegal;
    sticky_d  = sticky_q;
    if (illegal_clr) sticky_d = 1'b0;
    if (illegal_d)   sticky_d = 1'b1;
  end

  // Illegal pulse and sticky registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
      sticky_q  <= sticky_d;
    end
  end

  assign illegal        = illegal_q;
  assign illegal_sticky = sticky_q;
`else
  // Trap disabled: the undefined-code flag and clear input are not used.
  logic unused_trap;
  assign unused_trap    = dec_illegal ^ illegal_clr;
  assign illegal        = 1'b0;
  assign illegal_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed steps followed by random
// loads, compared against a rule-level reference model.
module tb_alu_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] aluop;
  logic [3:0] functcode;
  logic       illegal_clr;
  logic [2:0] alucont;
  logic       is_shift;
  logic       is_sub;
  logic       illegal;
  logic       illegal_sticky;

  int checks = 0;
  int passed = 0;

  // Reference model state: what each output should read now.
  logic [2:0] m_alucont;
  logic       m_shift;
  logic       m_sub;
  logic       m_ill;
  logic       m_sticky;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  alu_control dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .aluop          (aluop),
    .functcode      (functcode),
    .illegal_clr    (illegal_clr),
    .alucont        (alucont),
    .is_shift       (is_shift),
    .is_sub         (is_sub),
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".alucont"},  {1'b0, alucont},  {1'b0, m_alucont});
    check({tag, ".is_shift"}, {3'b0, is_shift}, {3'b0, m_shift});
    check({tag, ".is_sub"},   {3'b0, is_sub},   {3'b0, m_sub});
    check({tag, ".illegal"},  {3'b0, illegal},  {3'b0, m_ill});
    check({tag, ".sticky"},   {3'b0, illegal_sticky}, {3'b0, m_sticky});
  endtask

  task automatic model_reset();
    m_alucont = 3'd0;
    m_shift   = 1'b0;
    m_sub     = 1'b0;
    m_ill     = 1'b0;
    m_sticky  = 1'b0;
  endtask

  // One clock of the reference behaviour, straight from the decode rules.
  task automatic model_clock(input logic e, input logic [1:0] op,
                             input logic [3:0] f, input logic c);
    int  sel;
    bit  bad;
    bad = 1'b0;
    if (e) begin
      if (op == 2'd0)      sel = 0;
      else if (op == 2'd1) sel = 1;
      else if (op == 2'd3) sel = 4;
      else if (f >= 4'd8) begin sel = 0; bad = 1'b1; end
      else                 sel = int'(f);
      m_alucont = sel[2:0];
      m_shift   = (sel == 3 || sel == 5 || sel == 6 || sel == 7);
      m_sub     = (sel == 1);
    end
    m_ill = TRAP && bad;
    if (TRAP) begin
      if (bad)    m_sticky = 1'b1;
      else if (c) m_sticky = 1'b0;
    end
  endtask

  // Drive inputs just after an edge, clock once, then sample 1 ns later.
  task automatic apply(input string tag, input logic e, input logic [1:0] op,
                       input logic [3:0] f, input logic c);
    en = e; aluop = op; functcode = f; illegal_clr = c;
    @(posedge clk);
    model_clock(e, op, f, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; aluop = 2'd0; functcode = 4'd0; illegal_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    apply("add", 1'b1, 2'b00, 4'b0000, 1'b0);
    apply("sub", 1'b1, 2'b01, 4'b0111, 1'b0);
    apply("neg", 1'b1, 2'b11, 4'b0111, 1'b0);

    for (int k = 0; k < 8; k++) begin
      logic [3:0] fc;
      fc = 4'(k);
      apply($sformatf("funct%0d", k), 1'b1, 2'b10, fc, 1'b0);
    end

    apply("illegal", 1'b1, 2'b10, 4'b1010, 1'b0);
    apply("ill_hold", 1'b0, 2'b00, 4'b0000, 1'b0);
    apply("ill_b2b_a", 1'b1, 2'b10, 4'b1111, 1'b0);
    apply("ill_b2b_b", 1'b1, 2'b10, 4'b1000, 1'b0);
    apply("sticky_keep", 1'b1, 2'b00, 4'b0000, 1'b0);
    apply("sticky_clr", 1'b0, 2'b00, 4'b0000, 1'b1);
    apply("sticky_zero", 1'b0, 2'b00, 4'b0000, 1'b0);
    apply("ill_vs_clr", 1'b1, 2'b10, 4'b1001, 1'b1);

    apply("load_asr", 1'b1, 2'b10, 4'b0101, 1'b0);
    apply("hold_a", 1'b0, 2'b01, 4'b0000, 1'b0);
    apply("hold_b", 1'b0, 2'b10, 4'b1110, 1'b1);

    for (int k = 0; k < 300; k++) begin
      logic       re;
      logic [1:0] rop;
      logic [3:0] rf;
      logic       rc;
      re  = ($urandom_range(0, 3) != 0);
      rop = 2'($urandom_range(0, 3));
      rf  = 4'($urandom_range(0, 15));
      rc  = ($urandom_range(0, 7) == 0);
      apply("rand", re, rop, rf, rc);
    end

    // Async reset between edges with non-reset outputs present.
    apply("pre_rst_a", 1'b1, 2'b10, 4'b1100, 1'b0);
    apply("pre_rst_b", 1'b1, 2'b10, 4'b0110, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    apply("post_rst", 1'b1, 2'b01, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
